// File: rtl/muldiv_if.sv
// muldiv_if: launch/operand/status bundle between the execute stage and muldiv_sequencer.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  modport master (output start, funct3, srcA, srcB, kill, input busy, done, result);
  modport slave  (input start, funct3, srcA, srcB, kill, output busy, done, result);
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative RV32M shift-add multiplier / restoring divider on operand magnitudes.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply finish in one cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic    clk_i,
  input  logic    reset_i,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s, sa_s, sb_s, early_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, early_res_s, fix_res_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH+1:0]   rem_sh_s, diff_s;
  logic [2*WIDTH-1:0] prod_sgn_s;

  // Operand sign/magnitude conditioning and single-cycle special cases at launch
  always_comb begin
    accept_s = (state_q == S_IDLE) && bus.start && !bus.kill;
    sa_s = bus.srcA[WIDTH-1] && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110));
    sb_s = bus.srcB[WIDTH-1] && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                                 (bus.funct3 == 3'b110));
    mag_a_s = sa_s ? ({WIDTH{1'b0}} - bus.srcA) : bus.srcA;
    mag_b_s = sb_s ? ({WIDTH{1'b0}} - bus.srcB) : bus.srcB;
`ifdef MULDIV_EARLY_OUT_EN
    if (!bus.funct3[2]) begin
      early_s     = (bus.srcA == {WIDTH{1'b0}}) || (bus.srcB == {WIDTH{1'b0}});
      early_res_s = {WIDTH{1'b0}};
    end else if (bus.srcB == {WIDTH{1'b0}}) begin
      early_s     = 1'b1;
      early_res_s = bus.funct3[1] ? bus.srcA : {WIDTH{1'b1}};
    end else if (!bus.funct3[0] && (bus.srcA == MIN_NEG) && (bus.srcB == {WIDTH{1'b1}})) begin
      early_s     = 1'b1;
      early_res_s = bus.funct3[1] ? {WIDTH{1'b0}} : bus.srcA;
    end else begin
      early_s     = 1'b0;
      early_res_s = {WIDTH{1'b0}};
    end
`else
    early_s     = 1'b0;
    early_res_s = {WIDTH{1'b0}};
`endif
  end

  // Iteration datapath and sign/selection for the FIX step
  always_comb begin
    sum_s      = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    rem_sh_s   = {rem_q, prod_q[WIDTH-1]};
    diff_s     = rem_sh_s - {2'b00, mcand_q};
    prod_sgn_s = neg_q ? ({(2*WIDTH){1'b0}} - prod_q) : prod_q;
    case (op_q)
      3'b000:                 fix_res_s = prod_sgn_s[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_sgn_s[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res_s = div0_q ? {WIDTH{1'b1}} :
                                          (neg_q ? ({WIDTH{1'b0}} - prod_q[WIDTH-1:0]) : prod_q[WIDTH-1:0]);
      3'b110, 3'b111:         fix_res_s = neg_q ? ({WIDTH{1'b0}} - rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
      default:                fix_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Sequencer next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    div0_d   = div0_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          op_d   = bus.funct3;
          cnt_d  = {CW{1'b0}};
          // remainder takes the dividend's sign; everything else the XOR of operand signs
          neg_d  = (bus.funct3[2] && bus.funct3[1]) ? sa_s : (sa_s ^ sb_s);
          div0_d = (bus.srcB == {WIDTH{1'b0}});
          rem_d  = {(WIDTH+1){1'b0}};
          if (bus.funct3[2]) begin
            prod_d  = {{WIDTH{1'b0}}, mag_a_s};
            mcand_d = mag_b_s;
          end else begin
            prod_d  = {{WIDTH{1'b0}}, mag_b_s};
            mcand_d = mag_a_s;
          end
          if (early_s) begin
            state_d  = S_DONE;
            result_d = early_res_s;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            rem_d  = diff_s[WIDTH+1] ? rem_sh_s[WIDTH:0] : diff_s[WIDTH:0];
            prod_d = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-2:0], ~diff_s[WIDTH+1]};
          end else begin
            prod_d = {sum_s, prod_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST) begin
            cnt_d   = {CW{1'b0}};
            state_d = S_FIX;
          end else begin
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            state_d = S_CALC;
          end
        end
      end
      S_FIX: begin
        if (bus.kill) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res_s;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      op_q     <= 3'b000;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      mcand_q  <= {WIDTH{1'b0}};
      prod_q   <= {(2*WIDTH){1'b0}};
      rem_q    <= {(WIDTH+1){1'b0}};
      result_q <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      div0_q   <= div0_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule
